// File: rtl/multicycle_control_pkg.sv
// rtl/multicycle_control_pkg.sv - state encodings, ALUOp codes, opcode patterns and instruction classes
package multicycle_control_pkg;

   typedef enum logic [2:0] {
      ST_FETCH  = 3'd0,
      ST_DECODE = 3'd1,
      ST_EXEC   = 3'd2,
      ST_MEM    = 3'd3,
      ST_WB     = 3'd4,
      ST_TRAP   = 3'd5
   } state_t;

   typedef enum logic [2:0] {
      CLS_RTYPE = 3'd0,
      CLS_LDUR  = 3'd1,
      CLS_STUR  = 3'd2,
      CLS_CBZ   = 3'd3,
      CLS_B     = 3'd4,
      CLS_NONE  = 3'd5
   } instr_class_t;

   localparam logic [1:0] ALUOP_DTYPE  = 2'b00;
   localparam logic [1:0] ALUOP_BRANCH = 2'b01;
   localparam logic [1:0] ALUOP_RTYPE  = 2'b10;

   // instruction[31:21]; '?' bits belong to the immediate field
   localparam logic [10:0] OP_ADD  = 11'b10001011000;
   localparam logic [10:0] OP_SUB  = 11'b11001011000;
   localparam logic [10:0] OP_AND  = 11'b10001010000;
   localparam logic [10:0] OP_ORR  = 11'b10101010000;
   localparam logic [10:0] OP_LDUR = 11'b11111000010;
   localparam logic [10:0] OP_STUR = 11'b11111000000;
   localparam logic [10:0] OP_CBZ  = 11'b10110100???;
   localparam logic [10:0] OP_B    = 11'b000101?????;

endpackage

// File: rtl/multicycle_control_if.sv
// rtl/multicycle_control_if.sv - memory request/ready handshake between control unit and memory
interface multicycle_control_if;
   logic mem_req;
   logic mem_we;
   logic mem_ready;

   modport master (output mem_req, output mem_we, input mem_ready);
   modport slave  (input mem_req, input mem_we, output mem_ready);
endinterface

// File: rtl/multicycle_control_instr_classify.sv
// rtl/multicycle_control_instr_classify.sv - opcode to instruction class and illegal flag
module instr_classify
   import multicycle_control_pkg::*;
(
   input  logic [10:0]  opcode_bits,
   output instr_class_t instr_class,
   output logic         illegal
);

   // wildcard match; '?' opcode bits are immediate bits and never affect the class
   always_comb begin
      instr_class = CLS_NONE;
      illegal     = 1'b0;
      casez (opcode_bits)
         OP_ADD, OP_SUB, OP_AND, OP_ORR: instr_class = CLS_RTYPE;
         OP_LDUR:                        instr_class = CLS_LDUR;
         OP_STUR:                        instr_class = CLS_STUR;
         OP_CBZ:                         instr_class = CLS_CBZ;
         OP_B:                           instr_class = CLS_B;
         default:                        illegal     = 1'b1;
      endcase
   end

endmodule

// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - multicycle LEGv8 control FSM; CYCLE_COUNT_EN adds cycle/instruction counters
module multicycle_control
   import multicycle_control_pkg::*;
#(
   parameter int MEM_WAIT_MAX = 15
)(
   input  logic                        clk,
   input  logic                        reset,
   input  logic [10:0]                 opcode_bits,
   input  logic                        zero,
   multicycle_control_if.master        mem,
   output logic                        ir_write,
   output logic                        pc_write,
   output logic                        reg_write,
   output logic                        pc_src,
   output logic                        reg2_loc,
   output logic                        alu_src,
   output logic                        mem_to_reg,
   output logic [1:0]                  alu_op,
   output logic [2:0]                  state,
   output logic                        illegal,
   output logic                        mem_fault
`ifdef CYCLE_COUNT_EN
   ,
   output logic [31:0]                 cycle_count,
   output logic [31:0]                 instr_count
`endif
);

   localparam int             WCW       = $clog2(MEM_WAIT_MAX + 1);
   localparam logic [WCW-1:0] WAIT_LAST = WCW'(MEM_WAIT_MAX - 1);
   localparam logic [WCW-1:0] WAIT_ONE  = WCW'(1);

   state_t         state_q, state_d;
   logic [WCW-1:0] wait_q, wait_d;
   logic           illegal_q, illegal_d;
   logic           fault_q, fault_d;
   logic           req, we;
   instr_class_t   cls;
   logic           cls_illegal;

   instr_classify u_classify (
      .opcode_bits (opcode_bits),
      .instr_class (cls),
      .illegal     (cls_illegal)
   );

   // next state, trap causes and the strobes of the current state
   always_comb begin
      state_d    = state_q;
      wait_d     = '0;
      illegal_d  = illegal_q;
      fault_d    = fault_q;
      req        = 1'b0;
      we         = 1'b0;
      ir_write   = 1'b0;
      pc_write   = 1'b0;
      reg_write  = 1'b0;
      pc_src     = 1'b0;
      reg2_loc   = 1'b0;
      alu_src    = 1'b0;
      mem_to_reg = 1'b0;
      alu_op     = ALUOP_DTYPE;
      case (state_q)
         ST_FETCH: begin
            req = 1'b1;
            if (mem.mem_ready) begin
               ir_write = 1'b1;
               pc_write = 1'b1;
               state_d  = ST_DECODE;
            end
         end
         ST_DECODE: begin
            reg2_loc = (cls == CLS_STUR) || (cls == CLS_CBZ);
            if (cls_illegal) begin
               state_d   = ST_TRAP;
               illegal_d = 1'b1;
            end else begin
               state_d = ST_EXEC;
            end
         end
         ST_EXEC: begin
            case (cls)
               CLS_RTYPE: begin
                  alu_op  = ALUOP_RTYPE;
                  state_d = ST_WB;
               end
               CLS_LDUR, CLS_STUR: begin
                  alu_op  = ALUOP_DTYPE;
                  alu_src = 1'b1;
                  state_d = ST_MEM;
               end
               CLS_CBZ: begin
                  alu_op   = ALUOP_BRANCH;
                  pc_src   = 1'b1;
                  pc_write = zero;
                  state_d  = ST_FETCH;
               end
               CLS_B: begin
                  pc_src   = 1'b1;
                  pc_write = 1'b1;
                  state_d  = ST_FETCH;
               end
               default: begin
                  state_d   = ST_TRAP;
                  illegal_d = 1'b1;
               end
            endcase
         end
         ST_MEM: begin
            req = 1'b1;
            we  = (cls == CLS_STUR);
            if (mem.mem_ready) begin
               state_d = (cls == CLS_STUR) ? ST_FETCH : ST_WB;
            end
         end
         ST_WB: begin
            reg_write  = 1'b1;
            mem_to_reg = (cls == CLS_LDUR);
            state_d    = ST_FETCH;
         end
         ST_TRAP: begin
            state_d = ST_TRAP;
         end
         default: begin
            state_d = ST_FETCH;
         end
      endcase
      // ready wins over the timeout: only a cycle still waiting can be the faulting one
      if (req && !mem.mem_ready) begin
         if (wait_q == WAIT_LAST) begin
            state_d = ST_TRAP;
            fault_d = 1'b1;
         end else begin
            wait_d = wait_q + WAIT_ONE;
         end
      end
      if (reset) begin
         req        = 1'b0;
         we         = 1'b0;
         ir_write   = 1'b0;
         pc_write   = 1'b0;
         reg_write  = 1'b0;
         pc_src     = 1'b0;
         reg2_loc   = 1'b0;
         alu_src    = 1'b0;
         mem_to_reg = 1'b0;
         alu_op     = ALUOP_DTYPE;
      end
   end

   // state, wait counter and sticky trap causes; reset returns to FETCH
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= ST_FETCH;
         wait_q    <= '0;
         illegal_q <= 1'b0;
         fault_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         wait_q    <= wait_d;
         illegal_q <= illegal_d;
         fault_q   <= fault_d;
      end
   end

   assign mem.mem_req = req;
   assign mem.mem_we  = we;
   assign state       = state_q;
   assign illegal     = illegal_q;
   assign mem_fault   = fault_q;

`ifdef CYCLE_COUNT_EN
   logic [31:0] cycle_q, cycle_d;
   logic [31:0] instr_q, instr_d;

   // an instruction retires when control returns to FETCH from a working state
   always_comb begin
      cycle_d = cycle_q + 32'd1;
      instr_d = instr_q;
      if (state_d == ST_FETCH &&
          (state_q == ST_EXEC || state_q == ST_MEM || state_q == ST_WB)) begin
         instr_d = instr_q + 32'd1;
      end
   end

   // free-running performance counters, wrapping at 2^32
   always_ff @(posedge clk) begin
      if (reset) begin
         cycle_q <= '0;
         instr_q <= '0;
      end else begin
         cycle_q <= cycle_d;
         instr_q <= instr_d;
      end
   end

   assign cycle_count = cycle_q;
   assign instr_count = instr_q;
`endif

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 Parameter MEM_WAIT_MAX, default 15, meaning: max cycles a memory request may wait for mem_ready before fault.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 opcode_bits  input  11  instruction[31:21] from the instruction register.
REQ-005 zero  input  1  ALU zero flag, valid during EXEC.
REQ-006 mem_ready  input  1  memory completion strobe for the current request.
REQ-007 mem_req  output  1  memory request, held until mem_ready or fault.
REQ-008 mem_we  output  1  write qualifier for mem_req (STUR only).
REQ-009 ir_write, pc_write, reg_write  output  1 each  load strobes: instruction register, PC, register file.
REQ-010 pc_src  output  1  0 = PC+4, 1 = branch target.
REQ-011 reg2_loc, alu_src, mem_to_reg  output  1 each  datapath muxes, meaning as in the single-cycle control unit.
REQ-012 alu_op  output  2  ALUOp_RTYPE / ALUOp_DTYPE / ALUOp_BRANCH from definitions.vh.
REQ-013 state  output  3  current FSM state encoding.
REQ-014 illegal, mem_fault  output  1 each  sticky trap causes.

Function
REQ-015 FSM states SHALL be FETCH, DECODE, EXEC, MEM, WB, TRAP.
REQ-016 FETCH: mem_req=1, mem_we=0; on mem_ready, ir_write=1, pc_write=1, pc_src=0 that cycle, then DECODE.
REQ-017 DECODE: one cycle, no strobes; reg2_loc=1 for STUR/CBZ, else 0; unrecognised opcode -> TRAP with illegal=1.
REQ-018 EXEC R-type (ADD/SUB/AND/ORR): alu_op=RTYPE, alu_src=0, then WB.
REQ-019 EXEC LDUR/STUR: alu_op=DTYPE, alu_src=1, then MEM.
REQ-020 EXEC CBZ: alu_op=BRANCH, pc_src=1, pc_write=zero, then FETCH.
REQ-021 EXEC B: pc_src=1, pc_write=1, then FETCH.
REQ-022 MEM: mem_req=1, mem_we=1 for STUR; on mem_ready, STUR -> FETCH, LDUR -> WB.
REQ-023 WB: reg_write=1 for exactly one cycle, mem_to_reg=1 for LDUR, 0 for R-type, then FETCH.
REQ-024 Zero-wait latency: R-type 4, LDUR 5, STUR 4, CBZ/B 3 cycles per instruction.
REQ-025 A wait counter SHALL count consecutive cycles with mem_req=1 and mem_ready=0; reaching MEM_WAIT_MAX -> TRAP with mem_fault=1, mem_req dropped next cycle.
REQ-026 mem_ready while mem_req=0 SHALL be ignored; mem_ready on the cycle the counter hits MEM_WAIT_MAX SHALL count as completion.
REQ-027 TRAP: all strobes and mem_req 0; stays until reset; illegal/mem_fault held.
REQ-028 Strobes SHALL be combinational from state and inputs; mux outputs 0 when don't-care.

Reset
REQ-029 reset SHALL take priority, including mid-wait, and next cycle yield state=FETCH, wait counter 0, illegal=0, mem_fault=0, counters 0.
REQ-030 While reset is high all strobes, including mem_req, SHALL be 0.

Configuration
REQ-031 With CYCLE_COUNT_EN defined: 32-bit outputs cycle_count (increments every non-reset cycle) and instr_count (increments on each return to FETCH from EXEC/MEM/WB), both wrapping at 2^32.
REQ-032 Without CYCLE_COUNT_EN: those ports and their registers SHALL be absent.

Structure
REQ-033 Opcode patterns (CBZ/B with x bits), ALUOp codes and state encodings SHALL live in definitions.vh.
REQ-034 One sub-module instr_classify SHALL map opcode_bits to instruction class plus illegal flag via casex.

Verification
REQ-035 ADD opcode 10001011000, mem_ready=1 in FETCH -> states FETCH,DECODE,EXEC,WB; reg_write=1 in cycle 4 only; alu_op=2'b10.
REQ-036 LDUR 11111000010, mem_ready delayed 3 cycles in MEM -> mem_req high 4 MEM cycles, WB with mem_to_reg=1, 8 total cycles.
REQ-037 CBZ 10110100xxx with zero=0 then zero=1 -> pc_write=0 then pc_write=1,pc_src=1 in EXEC.
REQ-038 opcode 11111111111 -> TRAP after DECODE, illegal=1, no strobes until reset; reset -> FETCH.
REQ-039 mem_ready held 0 in FETCH -> mem_fault=1 after 15 waiting cycles; reset asserted in cycle 7 of a wait -> FETCH, counter 0.
REQ-040 CYCLE_COUNT_EN build, 3 B instructions zero-wait -> instr_count=3, cycle_count=9.
